mmio_tx: RTL and testbench

Memory-mapped serial transmit peripheral on the data-memory side of the CPU. Sits downstream of the memory address register and claims MMIO writes and reads in a small register window. Bytes written to the data register are queued in a FIFO and shifted out as 8N1 UART frames. A status register is readable through the same window.

---
 rtl/mmio_tx.sv | 278 +++++++++++++++++++++++++++
 tb/tb_mmio_tx.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mmio_tx.sv
// mmio_tx: memory-mapped UART (8N1) transmit peripheral.
//
// A write to the DATA register queues a byte in a FIFO. The transmit FSM takes
// bytes from the FIFO and sends each one LSB-first on the serial line. When the
// FIFO still holds a byte at the end of a stop bit, the next frame starts with
// no idle gap.
//
// Register window (4 bytes at BASE_ADDR, selected when mmio=1):
//   +0 DATA    write: enqueue byte    read: STATUS
//   +1 STATUS  write: clear OVF       read: {4'b0, OVF, busy, full, empty}
//   +2 COUNT   read: FIFO occupancy (only when MMIO_TX_COUNT_EN is defined)
//   +3 -       reads 8'h00
//
// Optional feature macro: MMIO_TX_COUNT_EN enables the occupancy readback at +2.
// When it is not defined, +2 reads 8'h00.
//
// Ports:
//   clk       system clock; all logic on the rising edge
//   rst       synchronous active-high reset
//   addr      registered address from the address register
//   din       write data
//   write_en  memory write strobe
//   mmio      access targets IO space
//   dout      registered read data; 8'h00 when the window is not selected
//   tx        serial line; idles high
//   full      FIFO full, decoded combinationally from the occupancy counter
//
// FSM states:
//   state   | meaning
//   S_IDLE  | line high; waiting for a byte in the FIFO
//   S_START | sending the start bit (low)
//   S_DATA  | sending data bits 0..7, LSB first
//   S_STOP  | sending the stop bit (high)

module mmio_tx #(
  parameter int          CLK_DIV    = 104,
  parameter int          DEPTH_LOG2 = 4,
  parameter logic [7:0]  BASE_ADDR  = 8'hF0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] addr,
  input  logic [7:0] din,
  input  logic       write_en,
  input  logic       mmio,
  output logic [7:0] dout,
  output logic       tx,
  output logic       full
);

  localparam int         DEPTH       = 1 << DEPTH_LOG2;
  localparam int         PTR_W       = DEPTH_LOG2;
  localparam int         CNT_W       = DEPTH_LOG2 + 1;
  localparam logic [15:0] BAUD_RELOAD = 16'(CLK_DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_STOP
  } state_t;

  // FIFO storage and bookkeeping
  logic [7:0]       r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CNT_W-1:0] r_count;
  logic             r_ovf;
  logic [7:0]       r_dout;

  // Transmit FSM registers
  state_t      r_state;
  logic [15:0] r_baud;
  logic [2:0]  r_bit_idx;
  logic [7:0]  r_shift;
  logic        r_tx;

  // Next-state values
  state_t      w_nxt_state;
  logic [15:0] w_nxt_baud;
  logic [2:0]  w_nxt_bit;
  logic [7:0]  w_nxt_shift;
  logic        w_nxt_tx;
  logic        w_pop;

  logic       w_sel;
  logic [1:0] w_off;
  logic       w_full;
  logic       w_empty;
  logic       w_busy;
  logic       w_wr_data;
  logic       w_push;
  logic       w_drop;
  logic       w_ovf_clr;
  logic [7:0] w_head;
  logic [2:0] w_bit_inc;
  logic [7:0] w_status;
  logic [7:0] w_rd_data;

  assign w_sel   = mmio && (addr[7:2] == BASE_ADDR[7:2]);
  assign w_off   = addr[1:0];
  assign w_full  = (r_count == CNT_W'(DEPTH));
  assign w_empty = (r_count == '0);
  assign w_busy  = (r_state != S_IDLE);
  assign w_head  = r_mem[r_rd_ptr];

  // A pop in the same cycle frees the slot, so a write to a full FIFO is
  // accepted when the FSM drains the head on that edge.
  assign w_wr_data = w_sel && write_en && (w_off == 2'd0);
  assign w_push    = w_wr_data && (!w_full || w_pop);
  assign w_drop    = w_wr_data && w_full && !w_pop;
  assign w_ovf_clr = w_sel && write_en && (w_off == 2'd1);

  assign w_bit_inc = r_bit_idx + 3'd1;

  // --------------------------------------------------------------------------
  // FIFO
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      r_count <= r_count + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ovf <= 1'b0;
    end else if (w_drop) begin
      r_ovf <= 1'b1;
    end else if (w_ovf_clr) begin
      r_ovf <= 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Transmit FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_tx      <= 1'b1;
    end else begin
      r_state   <= w_nxt_state;
      r_baud    <= w_nxt_baud;
      r_bit_idx <= w_nxt_bit;
      r_shift   <= w_nxt_shift;
      r_tx      <= w_nxt_tx;
    end
  end

  always_comb begin
    w_nxt_state = r_state;
    w_nxt_baud  = r_baud;
    w_nxt_bit   = r_bit_idx;
    w_nxt_shift = r_shift;
    w_nxt_tx    = r_tx;
    w_pop       = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_nxt_tx = 1'b1;
        if (!w_empty) begin
          w_pop       = 1'b1;
          w_nxt_shift = w_head;
          w_nxt_tx    = 1'b0;
          w_nxt_baud  = BAUD_RELOAD;
          w_nxt_state = S_START;
        end
      end

      S_START: begin
        if (r_baud == 16'd0) begin
          w_nxt_tx    = r_shift[0];
          w_nxt_bit   = 3'd0;
          w_nxt_baud  = BAUD_RELOAD;
          w_nxt_state = S_DATA;
        end else begin
          w_nxt_baud = r_baud - 16'd1;
        end
      end

      S_DATA: begin
        if (r_baud == 16'd0) begin
          w_nxt_baud = BAUD_RELOAD;
          if (r_bit_idx == 3'd7) begin
            w_nxt_tx    = 1'b1;
            w_nxt_state = S_STOP;
          end else begin
            w_nxt_bit = w_bit_inc;
            w_nxt_tx  = r_shift[w_bit_inc];
          end
        end else begin
          w_nxt_baud = r_baud - 16'd1;
        end
      end

      S_STOP: begin
        if (r_baud == 16'd0) begin
          if (!w_empty) begin
            // Chain straight into the next start bit, keeping frames contiguous.
            w_pop       = 1'b1;
            w_nxt_shift = w_head;
            w_nxt_tx    = 1'b0;
            w_nxt_baud  = BAUD_RELOAD;
            w_nxt_state = S_START;
          end else begin
            w_nxt_tx    = 1'b1;
            w_nxt_state = S_IDLE;
          end
        end else begin
          w_nxt_baud = r_baud - 16'd1;
        end
      end

      default: begin
        w_nxt_tx    = 1'b1;
        w_nxt_state = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Register readback; status reflects state before this edge's updates.
  // --------------------------------------------------------------------------
  assign w_status = {4'b0000, r_ovf, w_busy, w_full, w_empty};

`ifdef MMIO_TX_COUNT_EN
  logic [8:0] w_cnt9;
  logic [7:0] w_cnt_rd;
  assign w_cnt9   = 9'(r_count);
  assign w_cnt_rd = (w_cnt9 > 9'd255) ? 8'hFF : w_cnt9[7:0];
`endif

  always_comb begin
    w_rd_data = 8'h00;
    if (w_sel) begin
      case (w_off)
        2'd0, 2'd1: w_rd_data = w_status;
`ifdef MMIO_TX_COUNT_EN
        2'd2:       w_rd_data = w_cnt_rd;
`endif
        default:    w_rd_data = 8'h00;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dout <= 8'h00;
    end else begin
      r_dout <= w_rd_data;
    end
  end

  assign dout = r_dout;
  assign tx   = r_tx;
  assign full = w_full;

endmodule

// File: tb/tb_mmio_tx.sv
// Testbench for mmio_tx. The reference model keeps the list of accepted bytes
// with the cycle each frame starts; FIFO occupancy, busy and drop decisions are
// derived from that timeline. Two monitors compare read data and serial frames
// against queued expectations.

module tb_mmio_tx;

  localparam int         CD    = 4;
  localparam int         DL    = 2;
  localparam int         DEPTH = 1 << DL;
  localparam int         FRAME = 10 * CD;
  localparam logic [7:0] BASE  = 8'hF0;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] addr = 8'h00;
  logic [7:0] din = 8'h00;
  logic       write_en = 1'b0;
  logic       mmio = 1'b0;
  logic [7:0] dout;
  logic       tx;
  logic       full;

  mmio_tx #(.CLK_DIV(CD), .DEPTH_LOG2(DL), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .addr(addr), .din(din), .write_en(write_en),
    .mmio(mmio), .dout(dout), .tx(tx), .full(full)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  typedef struct { int acc; int st; } frame_t;
  typedef struct { logic [7:0] b; int st; } txexp_t;
  typedef struct { logic [7:0] v; int at; } rdexp_t;

  frame_t frames[$];
  txexp_t tx_q[$];
  rdexp_t rd_q[$];

  int last_start = -100000;
  bit ovf_m = 1'b0;
  int reset_edge = -1;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  // Bytes sitting in the FIFO after edge t: accepted by t, not yet started.
  function automatic int occ(int t);
    int n = 0;
    foreach (frames[i]) if (frames[i].acc <= t && frames[i].st > t) n++;
    return n;
  endfunction

  function automatic bit busy_at(int t);
    foreach (frames[i]) if (frames[i].st <= t && t <= frames[i].st + FRAME - 1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pop_at(int e);
    foreach (frames[i]) if (frames[i].st == e) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic exp_bit(logic [7:0] b, int idx);
    if (idx == 0) return 1'b0;
    if (idx == 9) return 1'b1;
    return b[idx-1];
  endfunction

  // One bus cycle: inputs applied after edge k, sampled at edge e = k+1.
  task automatic drive(bit r, bit m, logic [7:0] a, bit we, logic [7:0] d);
    int k, e, st;
    bit sel;
    logic [7:0] ev;
    @(posedge clk);
    #1;
    k = cyc;
    e = k + 1;
    check("full", full, occ(k) == DEPTH);
    rst = r; mmio = m; addr = a; write_en = we; din = d;
    sel = m && (a[7:2] == BASE[7:2]);
    ev = 8'h00;
    if (!r && sel) begin
      case (a[1:0])
        2'd0, 2'd1: ev = {4'b0000, ovf_m, busy_at(k), occ(k) == DEPTH, occ(k) == 0};
`ifdef MMIO_TX_COUNT_EN
        2'd2: ev = 8'(occ(k));
`endif
        default: ev = 8'h00;
      endcase
    end
    rd_q.push_back('{ev, e});
    if (r) begin
      frames.delete();
      tx_q.delete();
      ovf_m = 1'b0;
      last_start = -100000;
      reset_edge = e;
    end else if (sel && we) begin
      if (a[1:0] == 2'd0) begin
        if (occ(k) < DEPTH || pop_at(e)) begin
          st = (e + 1 > last_start + FRAME) ? e + 1 : last_start + FRAME;
          frames.push_back('{e, st});
          tx_q.push_back('{d, st});
          last_start = st;
        end else begin
          ovf_m = 1'b1;
        end
      end else if (a[1:0] == 2'd1) begin
        ovf_m = 1'b0;
      end
    end
    while (frames.size() > 0 && frames[0].st + FRAME < k) void'(frames.pop_front());
  endtask

  task automatic idle(int n);
    repeat (n) drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
  endtask

  task automatic drain();
    int n = 0;
    while ((tx_q.size() != 0 || busy_at(cyc)) && n < 3000) begin
      drive(1'b0, 1'b0, 8'h00, 1'b0, 8'h00);
      n++;
    end
    check("drain_done", tx_q.size(), 0);
    idle(3);
  endtask

  // Read-data monitor
  always begin : rd_mon
    @(negedge clk);
    if (rd_q.size() > 0 && rd_q[0].at == cyc) begin
      check("dout", dout, rd_q[0].v);
      void'(rd_q.pop_front());
    end else if (rd_q.size() > 0 && rd_q[0].at < cyc) begin
      check("dout_stale", rd_q[0].at, cyc);
      void'(rd_q.pop_front());
    end
  end

  // Serial-line monitor
  txexp_t     m_ex;
  int         m_st;
  int         m_errs;
  logic [7:0] m_rx;
  bit         m_abort;

  always begin : tx_mon
    @(negedge clk);
    if (tx === 1'b0) begin
      if (tx_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL tx_unexpected_start cyc=%0d got=0 expected=1", cyc);
      end else begin
        m_ex = tx_q.pop_front();
        m_st = cyc;
        m_errs = 0;
        m_rx = 8'h00;
        m_abort = 1'b0;
        check("frame_start", m_st, m_ex.st);
        for (int j = 0; j < FRAME; j++) begin
          if (j > 0) @(negedge clk);
          if (reset_edge > m_st && cyc >= reset_edge) begin
            check("rst_tx_idle", tx, 1);
            m_abort = 1'b1;
            break;
          end
          if (tx !== exp_bit(m_ex.b, j / CD)) m_errs++;
          if ((j % CD) == CD / 2 && j / CD >= 1 && j / CD <= 8) m_rx[j/CD-1] = tx;
        end
        if (!m_abort) begin
          check("frame_byte", m_rx, m_ex.b);
          check("frame_shape_errs", m_errs, 0);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    repeat (3) drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(2);

    // single frame, status during and after
    drive(1'b0, 1'b1, BASE, 1'b1, 8'h55);
    idle(5);
    drive(1'b0, 1'b1, BASE + 8'd1, 1'b0, 8'h00);
    idle(10);
    drive(1'b0, 1'b1, BASE, 1'b0, 8'h00);
    drain();
    drive(1'b0, 1'b1, BASE, 1'b0, 8'h00);

    // back-to-back frames
    drive(1'b0, 1'b1, BASE, 1'b1, 8'h01);
    drive(1'b0, 1'b1, BASE, 1'b1, 8'h80);
    drive(1'b0, 1'b1, BASE, 1'b1, 8'hFF);
    drain();

    // overflow: 6 consecutive writes into a 4-deep FIFO
    for (int i = 0; i < 6; i++) drive(1'b0, 1'b1, BASE, 1'b1, 8'(8'h10 + i));
    drive(1'b0, 1'b1, BASE + 8'd1, 1'b0, 8'h00);
    drive(1'b0, 1'b1, BASE + 8'd1, 1'b1, 8'hAA);
    drive(1'b0, 1'b1, BASE, 1'b0, 8'h00);
    drain();

    // reset mid-DATA
    drive(1'b0, 1'b1, BASE, 1'b1, 8'hA5);
    drive(1'b0, 1'b1, BASE, 1'b1, 8'h5A);
    idle(15);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 8'h00);
    idle(60);
    drive(1'b0, 1'b1, BASE, 1'b0, 8'h00);

    // out-of-window accesses
    drive(1'b0, 1'b0, BASE, 1'b1, 8'h33);
    drive(1'b0, 1'b1, BASE + 8'd4, 1'b1, 8'h44);
    drive(1'b0, 1'b0, BASE, 1'b0, 8'h00);
    drive(1'b0, 1'b1, BASE + 8'd4, 1'b0, 8'h00);
    drive(1'b0, 1'b1, BASE + 8'd3, 1'b0, 8'h00);
    idle(50);

    // occupancy readback with two bytes queued behind an active frame
    drive(1'b0, 1'b1, BASE, 1'b1, 8'hC3);
    drive(1'b0, 1'b1, BASE, 1'b1, 8'h3C);
    drive(1'b0, 1'b1, BASE, 1'b1, 8'h99);
    drive(1'b0, 1'b1, BASE + 8'd2, 1'b0, 8'h00);
    drive(1'b0, 1'b1, BASE + 8'd2, 1'b0, 8'h00);
    drain();

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      bit r, m, we;
      logic [7:0] a;
      r  = ($urandom_range(0, 249) == 0);
      m  = ($urandom_range(0, 9) != 0);
      a  = ($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'(BASE + 8'($urandom_range(0, 7)));
      we = ($urandom_range(0, 2) == 0);
      drive(r, m, a, we, 8'($urandom));
    end
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
